// File: rtl/txn_arb_pkg.sv
// Shared types and constants for the transaction arbiter: lane state
// encoding, response codes and the requester-index width helper.
package txn_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } lane_state_e;

  localparam logic RESP_OK  = 1'b0;
  localparam logic RESP_ERR = 1'b1;

  // Width of a requester index; never narrower than one bit.
  function automatic int idx_width(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/txn_arbiter_lane.sv
// One arbitrated lane: round-robin grant, single outstanding transaction,
// slave wait timeout and completion routing back to the granted manager.
module arb_lane
  import txn_arb_pkg::*;
#(
  parameter int N_REQ      = 2,
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 32,
  parameter int ID_WIDTH   = 4,
  parameter int TIMEOUT    = 16,
  parameter bit READ_LANE  = 1'b0,
  parameter int IDX_W      = idx_width(N_REQ)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [N_REQ-1:0]              req_valid_i,
  input  logic [N_REQ*ADDR_WIDTH-1:0]   req_addr_i,
  input  logic [N_REQ*DATA_WIDTH-1:0]   req_data_i,
  input  logic [N_REQ*ID_WIDTH-1:0]     req_id_i,
  output logic [N_REQ-1:0]              cpl_ready_o,
  output logic                          cpl_resp_o,
  output logic                          s_valid_o,
  output logic [ADDR_WIDTH-1:0]         s_addr_o,
  output logic [ID_WIDTH+IDX_W-1:0]     s_id_o,
  output logic [DATA_WIDTH-1:0]         data_o,
  input  logic                          s_ready_i,
  input  logic                          s_resp_i,
  input  logic [DATA_WIDTH-1:0]         s_rdata_i
);

  localparam int CNT_W = $clog2(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [N_REQ-1:0] ONE_HOT0 = N_REQ'(1);

  lane_state_e               state_q;
  logic [IDX_W-1:0]          ptr_q;
  logic [IDX_W-1:0]          g_q;
  logic [CNT_W-1:0]          cnt_q;
  logic                      s_valid_q;
  logic [ADDR_WIDTH-1:0]     addr_q;
  logic [ID_WIDTH+IDX_W-1:0] id_q;
  // Write lane: latched write data. Read lane: returned read data.
  logic [DATA_WIDTH-1:0]     data_q;
  logic [N_REQ-1:0]          ready_q;
  logic                      resp_q;

  logic [IDX_W-1:0]          grant_d;
  logic [IDX_W-1:0]          ptr_d;
  logic                      req_any_d;

  function automatic logic [IDX_W-1:0] rr_pos(input logic [IDX_W-1:0] base, input int off);
    return IDX_W'((int'(base) + off) % N_REQ);
  endfunction

  // Round-robin search: walk backwards so the requester closest to ptr wins.
  always_comb begin
    grant_d   = '0;
    req_any_d = 1'b0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      grant_d   = req_valid_i[rr_pos(ptr_q, k)] ? rr_pos(ptr_q, k) : grant_d;
      req_any_d = req_any_d | req_valid_i[rr_pos(ptr_q, k)];
    end
    ptr_d = (grant_d == IDX_W'(N_REQ - 1)) ? '0 : grant_d + IDX_W'(1);
  end

  // Lane FSM with latched request fields and registered completion.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      ptr_q     <= '0;
      g_q       <= '0;
      cnt_q     <= '0;
      s_valid_q <= 1'b0;
      addr_q    <= '0;
      id_q      <= '0;
      data_q    <= '0;
      ready_q   <= '0;
      resp_q    <= RESP_OK;
    end else begin
      case (state_q)
        IDLE: begin
          ready_q <= '0;
          if (req_any_d) begin
            state_q   <= BUSY;
            g_q       <= grant_d;
            ptr_q     <= ptr_d;
            cnt_q     <= '0;
            s_valid_q <= 1'b1;
            addr_q    <= req_addr_i[grant_d*ADDR_WIDTH +: ADDR_WIDTH];
            id_q      <= {grant_d, req_id_i[grant_d*ID_WIDTH +: ID_WIDTH]};
            data_q    <= READ_LANE ? '0 : req_data_i[grant_d*DATA_WIDTH +: DATA_WIDTH];
          end
        end
        BUSY: begin
          if (s_ready_i) begin
            state_q   <= RESP;
            s_valid_q <= 1'b0;
            ready_q   <= ONE_HOT0 << g_q;
            resp_q    <= s_resp_i;
            data_q    <= READ_LANE ? s_rdata_i : data_q;
          end else if (cnt_q == CNT_LAST) begin
            // Slave never answered: abort with an error and zero data.
            state_q   <= RESP;
            s_valid_q <= 1'b0;
            ready_q   <= ONE_HOT0 << g_q;
            resp_q    <= RESP_ERR;
            data_q    <= READ_LANE ? '0 : data_q;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        RESP: begin
          state_q <= IDLE;
          ready_q <= '0;
        end
        default: begin
          state_q   <= IDLE;
          s_valid_q <= 1'b0;
          ready_q   <= '0;
        end
      endcase
    end
  end

  assign cpl_ready_o = ready_q;
  assign cpl_resp_o  = resp_q;
  assign s_valid_o   = s_valid_q;
  assign s_addr_o    = addr_q;
  assign s_id_o      = id_q;
  assign data_o      = data_q;

endmodule

// File: rtl/txn_arbiter.sv
// Shares one slave write channel and one slave read channel between N_REQ
// managers; each channel is an independent arb_lane.
module txn_arbiter
  import txn_arb_pkg::*;
#(
  parameter int N_REQ      = 2,
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 32,
  parameter int ID_WIDTH   = 4,
  parameter int TIMEOUT    = 16,
  localparam int IDX_W     = idx_width(N_REQ)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [N_REQ-1:0]            m_wvalid,
  input  logic [N_REQ*ADDR_WIDTH-1:0] m_waddr,
  input  logic [N_REQ*DATA_WIDTH-1:0] m_wdata,
  input  logic [N_REQ*ID_WIDTH-1:0]   m_wid,
  output logic [N_REQ-1:0]            m_wready,
  output logic                        m_wresp,
  input  logic [N_REQ-1:0]            m_rvalid,
  input  logic [N_REQ*ADDR_WIDTH-1:0] m_raddr,
  input  logic [N_REQ*ID_WIDTH-1:0]   m_rid,
  output logic [N_REQ-1:0]            m_rready,
  output logic                        m_rresp,
  output logic [DATA_WIDTH-1:0]       m_rdata,
  output logic                        s_wvalid,
  output logic [ADDR_WIDTH-1:0]       s_waddr,
  output logic [DATA_WIDTH-1:0]       s_wdata,
  output logic [ID_WIDTH+IDX_W-1:0]   s_wid,
  input  logic                        s_wready,
  input  logic                        s_wresp,
  output logic                        s_rvalid,
  output logic [ADDR_WIDTH-1:0]       s_raddr,
  output logic [ID_WIDTH+IDX_W-1:0]   s_rid,
  input  logic                        s_rready,
  input  logic                        s_rresp,
  input  logic [DATA_WIDTH-1:0]       s_rdata
);

  arb_lane #(
    .N_REQ(N_REQ), .ADDR_WIDTH(ADDR_WIDTH), .DATA_WIDTH(DATA_WIDTH),
    .ID_WIDTH(ID_WIDTH), .TIMEOUT(TIMEOUT), .READ_LANE(1'b0)
  ) u_wr_lane (
    .clk(clk), .rst(rst),
    .req_valid_i(m_wvalid), .req_addr_i(m_waddr), .req_data_i(m_wdata), .req_id_i(m_wid),
    .cpl_ready_o(m_wready), .cpl_resp_o(m_wresp),
    .s_valid_o(s_wvalid), .s_addr_o(s_waddr), .s_id_o(s_wid), .data_o(s_wdata),
    .s_ready_i(s_wready), .s_resp_i(s_wresp), .s_rdata_i('0)
  );

  arb_lane #(
    .N_REQ(N_REQ), .ADDR_WIDTH(ADDR_WIDTH), .DATA_WIDTH(DATA_WIDTH),
    .ID_WIDTH(ID_WIDTH), .TIMEOUT(TIMEOUT), .READ_LANE(1'b1)
  ) u_rd_lane (
    .clk(clk), .rst(rst),
    .req_valid_i(m_rvalid), .req_addr_i(m_raddr), .req_data_i('0), .req_id_i(m_rid),
    .cpl_ready_o(m_rready), .cpl_resp_o(m_rresp),
    .s_valid_o(s_rvalid), .s_addr_o(s_raddr), .s_id_o(s_rid), .data_o(m_rdata),
    .s_ready_i(s_rready), .s_resp_i(s_rresp), .s_rdata_i(s_rdata)
  );

endmodule

// File: tb/tb_txn_arbiter.sv
// Directed bench for txn_arbiter with a transaction-level reference model
// compared against the DUT on every falling edge.
module tb_txn_arbiter;

  localparam int N   = 2;
  localparam int AW  = 8;
  localparam int DW  = 32;
  localparam int IW  = 4;
  localparam int TO  = 16;
  localparam int IDX = 1;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    m_wvalid, m_rvalid;
  logic [N*AW-1:0] m_waddr, m_raddr;
  logic [N*DW-1:0] m_wdata;
  logic [N*IW-1:0] m_wid, m_rid;
  logic [N-1:0]    m_wready, m_rready;
  logic            m_wresp, m_rresp;
  logic [DW-1:0]   m_rdata;
  logic            s_wvalid, s_rvalid;
  logic [AW-1:0]   s_waddr, s_raddr;
  logic [DW-1:0]   s_wdata;
  logic [IW+IDX-1:0] s_wid, s_rid;
  logic            s_wready, s_wresp, s_rready, s_rresp;
  logic [DW-1:0]   s_rdata;

  int checks = 0;
  int errors = 0;

  txn_arbiter #(.N_REQ(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ID_WIDTH(IW), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .m_wvalid(m_wvalid), .m_waddr(m_waddr), .m_wdata(m_wdata), .m_wid(m_wid),
    .m_wready(m_wready), .m_wresp(m_wresp),
    .m_rvalid(m_rvalid), .m_raddr(m_raddr), .m_rid(m_rid),
    .m_rready(m_rready), .m_rresp(m_rresp), .m_rdata(m_rdata),
    .s_wvalid(s_wvalid), .s_waddr(s_waddr), .s_wdata(s_wdata), .s_wid(s_wid),
    .s_wready(s_wready), .s_wresp(s_wresp),
    .s_rvalid(s_rvalid), .s_raddr(s_raddr), .s_rid(s_rid),
    .s_rready(s_rready), .s_rresp(s_rresp), .s_rdata(s_rdata)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Reference model: lane 0 = write, lane 1 = read. State reflects the
  // transaction picture after the most recent rising edge.
  bit            busy [2] = '{0, 0};
  bit            pulse[2] = '{0, 0};
  int            since[2] = '{0, 0};
  int            gnt  [2] = '{0, 0};
  int            ptr  [2] = '{0, 0};
  logic [AW-1:0] lat_a[2];
  logic [DW-1:0] lat_d[2];
  logic [IW-1:0] lat_i[2];
  logic          presp[2];
  logic [DW-1:0] pdata[2];
  int            cyc = 0;

  task automatic cmp_lane(input int l, input logic sv, input logic [AW-1:0] sa,
                          input logic [DW-1:0] sd, input logic [IW+IDX-1:0] sid,
                          input logic [N-1:0] mr, input logic mresp, input logic [DW-1:0] md);
    string p;
    p = (l == 0) ? "wr" : "rd";
    chk({p, "_s_valid"}, sv, busy[l]);
    chk({p, "_m_ready"}, mr, pulse[l] ? (64'd1 << gnt[l]) : 64'd0);
    if (busy[l]) begin
      chk({p, "_s_addr"}, sa, lat_a[l]);
      chk({p, "_s_id"}, sid, (64'(gnt[l]) << IW) | 64'(lat_i[l]));
      if (l == 0) chk({p, "_s_data"}, sd, lat_d[l]);
    end
    if (pulse[l]) begin
      chk({p, "_m_resp"}, mresp, presp[l]);
      if (l == 1) chk({p, "_m_rdata"}, md, pdata[l]);
    end
  endtask

  task automatic model_step();
    logic [N-1:0]  mv;
    logic          sr, sp;
    logic [DW-1:0] sd;
    bit            found;
    int            c;
    cyc++;
    for (int l = 0; l < 2; l++) begin
      mv = (l == 0) ? m_wvalid : m_rvalid;
      sr = (l == 0) ? s_wready : s_rready;
      sp = (l == 0) ? s_wresp : s_rresp;
      sd = (l == 0) ? '0 : s_rdata;
      if (rst) begin
        busy[l] = 0; pulse[l] = 0; ptr[l] = 0;
      end else if (pulse[l]) begin
        pulse[l] = 0;
      end else if (busy[l]) begin
        if (sr) begin
          busy[l] = 0; pulse[l] = 1; presp[l] = sp; pdata[l] = sd;
        end else if (cyc - since[l] == TO) begin
          busy[l] = 0; pulse[l] = 1; presp[l] = 1'b1; pdata[l] = '0;
        end
      end else begin
        found = 0;
        for (int k = 0; k < N; k++) begin
          c = (ptr[l] + k) % N;
          if (!found && mv[c]) begin
            found = 1;
            gnt[l] = c;
          end
        end
        if (found) begin
          busy[l]  = 1;
          since[l] = cyc;
          ptr[l]   = (gnt[l] + 1) % N;
          lat_a[l] = (l == 0) ? m_waddr[gnt[l]*AW +: AW] : m_raddr[gnt[l]*AW +: AW];
          lat_i[l] = (l == 0) ? m_wid[gnt[l]*IW +: IW] : m_rid[gnt[l]*IW +: IW];
          lat_d[l] = m_wdata[gnt[l]*DW +: DW];
        end
      end
    end
  endtask

  // Compare against the model, then advance it with the inputs the next edge sees.
  initial begin
    forever begin
      @(negedge clk);
      cmp_lane(0, s_wvalid, s_waddr, s_wdata, s_wid, m_wready, m_wresp, '0);
      cmp_lane(1, s_rvalid, s_raddr, '0, s_rid, m_rready, m_rresp, m_rdata);
      model_step();
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  task automatic serve_rd(input int eg, input bit reissue);
    int c;
    c = 0;
    while (!s_rvalid && c < 20) begin
      tick(1);
      c++;
    end
    chk("rd_wait", s_rvalid, 1'b1);
    chk("rd_grant", s_rid[IW+IDX-1 -: IDX], eg);
    chk("rd_addr", s_raddr, (eg == 1) ? 8'h44 : 8'h40);
    m_rvalid[eg] = 1'b0;
    s_rready = 1'b1; s_rdata = 32'hAAAA_AAAA; s_rresp = 1'b0;
    tick(1);
    chk("rd_ready", m_rready, 2'b01 << eg);
    chk("rd_data", m_rdata, 32'hAAAA_AAAA);
    s_rready = 1'b0; s_rdata = '0;
    if (reissue) m_rvalid[eg] = 1'b1;
    tick(1);
  endtask

  initial begin
    int n;
    rst = 1'b1;
    m_wvalid = '0; m_rvalid = '0; m_waddr = '0; m_raddr = '0;
    m_wdata = '0; m_wid = '0; m_rid = '0;
    s_wready = 1'b0; s_wresp = 1'b0; s_rready = 1'b0; s_rresp = 1'b0; s_rdata = '0;
    tick(3);
    chk("rst_ctrl", {s_wvalid, s_rvalid, m_wready, m_rready, m_wresp, m_rresp}, '0);
    chk("rst_fields", {s_waddr, s_wid, s_raddr, s_rid}, '0);
    chk("rst_data", {s_wdata, m_rdata}, '0);

    // Single write from mgr0
    rst = 1'b0;
    m_waddr[7:0] = 8'h10; m_wdata[31:0] = 32'h1111_1111; m_wid[3:0] = 4'h3;
    m_wvalid = 2'b01;
    tick(1);
    chk("t1_s_wvalid", s_wvalid, 1'b1);
    chk("t1_s_wid", s_wid, 5'h03);
    chk("t1_s_waddr", s_waddr, 8'h10);
    chk("t1_s_wdata", s_wdata, 32'h1111_1111);
    m_wvalid = 2'b00; s_wready = 1'b1; s_wresp = 1'b0;
    tick(1);
    chk("t1_m_wready", m_wready, 2'b01);
    chk("t1_m_wresp", m_wresp, 1'b0);
    s_wready = 1'b0;
    tick(1);
    chk("t1_pulse_len", m_wready, 2'b00);

    // Read contention with reissue: grants 0,1,0,1
    m_raddr = {8'h44, 8'h40}; m_rid = {4'h2, 4'h5};
    m_rvalid = 2'b11;
    serve_rd(0, 1'b1);
    serve_rd(1, 1'b1);
    serve_rd(0, 1'b0);
    serve_rd(1, 1'b0);

    // Write timeout from mgr1, then a late slave ready
    m_waddr[15:8] = 8'h20; m_wid[7:4] = 4'h7; m_wdata[63:32] = 32'h2222_2222;
    m_wvalid = 2'b10;
    tick(1);
    m_wvalid = 2'b00;
    n = 0;
    while (s_wvalid && n < 40) begin
      n++;
      tick(1);
    end
    chk("to_busy_cycles", n, 16);
    chk("to_m_wready", m_wready, 2'b10);
    chk("to_m_wresp", m_wresp, 1'b1);
    tick(4);
    s_wready = 1'b1;
    tick(1);
    s_wready = 1'b0;
    chk("to_late_ignored", {s_wvalid, m_wready}, 3'b000);
    tick(2);
    chk("to_late_quiet", m_wready, 2'b00);

    // Read ready on the final allowed edge
    m_rvalid = 2'b01;
    tick(1);
    m_rvalid = 2'b00;
    tick(15);
    chk("bd_still_busy", s_rvalid, 1'b1);
    s_rready = 1'b1; s_rdata = 32'h1234_5678; s_rresp = 1'b0;
    tick(1);
    chk("bd_m_rready", m_rready, 2'b01);
    chk("bd_m_rresp", m_rresp, 1'b0);
    chk("bd_m_rdata", m_rdata, 32'h1234_5678);
    s_rready = 1'b0; s_rdata = '0;
    tick(1);

    // Overlapping write (mgr1) and read (mgr0)
    m_wvalid = 2'b10; m_rvalid = 2'b01;
    tick(1);
    chk("cc_both_busy", {s_wvalid, s_rvalid}, 2'b11);
    chk("cc_s_wid", s_wid, 5'h17);
    chk("cc_s_rid", s_rid, 5'h05);
    m_wvalid = 2'b00; m_rvalid = 2'b00;
    tick(1);
    s_wready = 1'b1; s_wresp = 1'b1;
    tick(1);
    chk("cc_m_wready", m_wready, 2'b10);
    chk("cc_m_wresp", m_wresp, 1'b1);
    chk("cc_rd_pending", {s_rvalid, m_rready}, 3'b100);
    s_wready = 1'b0; s_wresp = 1'b0;
    tick(1);
    s_rready = 1'b1; s_rdata = 32'hCAFE_0001; s_rresp = 1'b1;
    tick(1);
    chk("cc_m_rready", m_rready, 2'b01);
    chk("cc_m_rdata", m_rdata, 32'hCAFE_0001);
    chk("cc_m_rresp", m_rresp, 1'b1);
    s_rready = 1'b0; s_rdata = '0; s_rresp = 1'b0;
    tick(2);

    // Reset mid-BUSY with both pointers at 1, then both managers request
    m_wvalid = 2'b01; m_rvalid = 2'b01;
    tick(1);
    m_wvalid = 2'b00; m_rvalid = 2'b00;
    tick(2);
    rst = 1'b1;
    tick(1);
    chk("rs_dropped", {s_wvalid, s_rvalid, m_wready, m_rready}, 6'b0);
    tick(1);
    rst = 1'b0;
    m_wvalid = 2'b11; m_rvalid = 2'b11;
    tick(1);
    chk("rs_w_grant0", s_wid[IW+IDX-1 -: IDX], 1'b0);
    chk("rs_r_grant0", s_rid[IW+IDX-1 -: IDX], 1'b0);
    m_wvalid = 2'b10; m_rvalid = 2'b10;
    s_wready = 1'b1; s_rready = 1'b1;
    tick(1);
    chk("rs_cpl", {m_wready, m_rready}, 4'b0101);
    s_wready = 1'b0; s_rready = 1'b0;
    m_wvalid = 2'b00; m_rvalid = 2'b00;
    tick(3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
